// File: rtl/shift_exec_pkg.sv
// Shared constants for the shift execute controller: opcodes, FSM encoding
// and instruction field positions (op | rd | rs | imm, MSB to LSB).
package shift_exec_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LI  = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    localparam int IMM_LSB = 0;

    function automatic int rs_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int op_lsb(input int data_w, input int addr_w);
        return data_w + 2 * addr_w;
    endfunction

endpackage

// File: rtl/shift_exec_regfile.sv
// 2**ADDR_W x DATA_W register file: async reset, one synchronous write port,
// combinational operand and debug read ports.
module shift_exec_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = regs_q[raddr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/shift_exec_ctrl.sv
// Fetch/decode/execute/writeback controller feeding an external shift ALU.
// Define SHIFT_EXEC_FLAGS_EN to add the flag_z / flag_c status outputs.
module shift_exec_ctrl
    import shift_exec_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int SHAMT_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [2+2*ADDR_W+DATA_W-1:0] instr,
    output logic [DATA_W-1:0]            alu_data_1,
    output logic [SHAMT_W-1:0]           alu_data_2,
    input  logic [DATA_W-1:0]            alu_out,
    output logic                         wb_done,
`ifdef SHIFT_EXEC_FLAGS_EN
    output logic                         flag_z,
    output logic                         flag_c,
`endif
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int INSTR_W = 2 + 2 * ADDR_W + DATA_W;
    localparam int RS_LSB  = rs_lsb(DATA_W);
    localparam int RD_LSB  = rd_lsb(DATA_W, ADDR_W);
    localparam int OP_LSB  = op_lsb(DATA_W, ADDR_W);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    op_a_q, op_a_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [DATA_W-1:0]    result_q, result_d;

    logic [1:0]           ir_op;
    logic [ADDR_W-1:0]    ir_rd, ir_rs;
    logic [DATA_W-1:0]    ir_imm;
    logic [DATA_W-1:0]    rf_rdata;
    logic                 rf_we;

    assign ir_op  = ir_q[OP_LSB +: 2];
    assign ir_rd  = ir_q[RD_LSB +: ADDR_W];
    assign ir_rs  = ir_q[RS_LSB +: ADDR_W];
    assign ir_imm = ir_q[IMM_LSB +: DATA_W];

    shift_exec_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (ir_rd),
        .wdata_i    (result_q),
        .raddr_i    (ir_rs),
        .rdata_o    (rf_rdata),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = (ir_op == OP_SLL) ? ST_EXEC : ST_WB;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        wb_done     = (state_q == ST_WB);
        rf_we       = (state_q == ST_WB) && (ir_op != OP_NOP);
    end

    // Operand registers double as the ALU inputs and hold outside DECODE.
    always_comb begin
        ir_d     = ir_q;
        op_a_d   = op_a_q;
        shamt_d  = shamt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: if (instr_valid) ir_d = instr;
            ST_DECODE: begin
                op_a_d  = rf_rdata;
                shamt_d = ir_imm[SHAMT_W-1:0];
                if (ir_op == OP_LI)  result_d = ir_imm;
                if (ir_op == OP_MOV) result_d = rf_rdata;
            end
            ST_EXEC: result_d = alu_out;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q     <= '0;
            op_a_q   <= '0;
            shamt_q  <= '0;
            result_q <= '0;
        end else begin
            ir_q     <= ir_d;
            op_a_q   <= op_a_d;
            shamt_q  <= shamt_d;
            result_q <= result_d;
        end
    end

    assign alu_data_1 = op_a_q;
    assign alu_data_2 = shamt_q;

`ifdef SHIFT_EXEC_FLAGS_EN
    logic                  flag_z_q, flag_z_d;
    logic                  flag_c_q, flag_c_d;
    logic [2*DATA_W-1:0]   shl_wide;

    // Carry = any set bit pushed above DATA_W by the shift.
    assign shl_wide = {{DATA_W{1'b0}}, op_a_q} << shamt_q;

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q == ST_WB && ir_op != OP_NOP) begin
            flag_z_d = (result_q == '0);
            flag_c_d = (ir_op == OP_SLL) && (|shl_wide[2*DATA_W-1:DATA_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_shift_exec_ctrl.sv
// Directed, table-driven bench for shift_exec_ctrl with a behavioural shift ALU.
module tb_shift_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [7:0]  alu_data_1;
    logic [2:0]  alu_data_2;
    logic [7:0]  alu_out;
    logic        wb_done;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
`ifdef SHIFT_EXEC_FLAGS_EN
    logic        flag_z, flag_c;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign alu_out = alu_data_1 << alu_data_2;

    shift_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_data_1  (alu_data_1),
        .alu_data_2  (alu_data_2),
        .alu_out     (alu_out),
        .wb_done     (wb_done),
`ifdef SHIFT_EXEC_FLAGS_EN
        .flag_z      (flag_z),
        .flag_c      (flag_c),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        int         lat;
        logic [7:0] old_v;
        logic [7:0] new_v;
        logic [7:0] a;
        logic [2:0] sh;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Handshake one instruction; return at #1 into the wb_done cycle.
    task automatic issue(input logic [15:0] ins, output int lat, output logic rdy1,
                         output logic [7:0] a2, output logic [2:0] sh2);
        int g;
        instr = ins;
        instr_valid = 1'b1;
        g = 0;
        while (!instr_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'hFFFF;
        lat = 1; rdy1 = instr_ready; a2 = '0; sh2 = '0;
        while (!wb_done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                a2 = alu_data_1;
                sh2 = alu_data_2;
            end
        end
    endtask

    initial begin
        int lat, g, wbc;
        logic rdy1;
        logic [7:0] a2, v;
        logic [2:0] sh2;
        logic [15:0] seq[8];

        vt[0]  = '{2'b01, 3'd3, 3'd0, 8'h5A, 2, 8'h00, 8'h5A, 8'h00, 3'd0};
        vt[1]  = '{2'b01, 3'd1, 3'd0, 8'h81, 2, 8'h00, 8'h81, 8'h00, 3'd0};
        vt[2]  = '{2'b10, 3'd2, 3'd1, 8'h03, 3, 8'h00, 8'h08, 8'h81, 3'd3};
        vt[3]  = '{2'b01, 3'd4, 3'd0, 8'h0F, 2, 8'h00, 8'h0F, 8'h00, 3'd0};
        vt[4]  = '{2'b10, 3'd4, 3'd4, 8'hF9, 3, 8'h0F, 8'h1E, 8'h0F, 3'd1};
        vt[5]  = '{2'b11, 3'd0, 3'd3, 8'h00, 2, 8'h00, 8'h5A, 8'h00, 3'd0};
        vt[6]  = '{2'b00, 3'd3, 3'd0, 8'hFF, 2, 8'h5A, 8'h5A, 8'h00, 3'd0};
        vt[7]  = '{2'b10, 3'd6, 3'd3, 8'h07, 3, 8'h00, 8'h00, 8'h5A, 3'd7};
        vt[8]  = '{2'b11, 3'd7, 3'd7, 8'h00, 2, 8'h00, 8'h00, 8'h00, 3'd0};
        vt[9]  = '{2'b01, 3'd7, 3'd0, 8'hFF, 2, 8'h00, 8'hFF, 8'h00, 3'd0};
        vt[10] = '{2'b10, 3'd7, 3'd7, 8'h08, 3, 8'hFF, 8'hFF, 8'hFF, 3'd0};
        vt[11] = '{2'b11, 3'd5, 3'd2, 8'h05, 2, 8'h00, 8'h08, 8'h00, 3'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", instr_ready, 1);
        chk("rst_wb_done", wb_done, 0);
        chk("rst_alu1", alu_data_1, 0);
        chk("rst_alu2", alu_data_2, 0);
        for (int r = 0; r < 8; r++) begin
            rd_reg(r[2:0], v);
            chk($sformatf("rst_r%0d", r), v, 0);
        end

        // Table-driven instruction vectors
        for (int i = 0; i < 12; i++) begin
            issue(mk(vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm), lat, rdy1, a2, sh2);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_ready_busy", i), rdy1, 0);
            if (vt[i].op == 2'b10) begin
                chk($sformatf("v%0d_exec_a", i), a2, vt[i].a);
                chk($sformatf("v%0d_exec_sh", i), sh2, vt[i].sh);
            end
            rd_reg(vt[i].rd, v);
            chk($sformatf("v%0d_wb_old", i), v, vt[i].old_v);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_back", i), instr_ready, 1);
            chk($sformatf("v%0d_wb_pulse", i), wb_done, 0);
            rd_reg(vt[i].rd, v);
            chk($sformatf("v%0d_new", i), v, vt[i].new_v);
        end
        chk("alu1_hold", alu_data_1, 8'h08);
        chk("alu2_hold", alu_data_2, 3'd5);

        // instr_valid held for 8 cycles; only IDLE-cycle instructions are taken
        seq[0] = mk(2'b11, 3'd6, 3'd0, 8'h00);
        seq[1] = mk(2'b01, 3'd6, 3'd0, 8'h11);
        seq[2] = mk(2'b01, 3'd5, 3'd0, 8'h22);
        seq[3] = mk(2'b11, 3'd5, 3'd4, 8'h00);
        seq[4] = mk(2'b01, 3'd0, 3'd0, 8'h33);
        seq[5] = mk(2'b01, 3'd0, 3'd0, 8'h44);
        seq[6] = mk(2'b11, 3'd1, 3'd3, 8'h00);
        seq[7] = mk(2'b01, 3'd1, 3'd0, 8'h77);
        wbc = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr = seq[i];
            #1;
            if (wb_done) wbc++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        chk("hold8_wb_count", wbc, 2);
        g = 0;
        while (!wb_done && g < 10) begin
            @(posedge clk); #1; g++;
        end
        chk("hold8_third_wb", wb_done, 1);
        @(posedge clk); #1;
        rd_reg(3'd6, v); chk("hold8_r6", v, 8'h5A);
        rd_reg(3'd5, v); chk("hold8_r5", v, 8'h1E);
        rd_reg(3'd1, v); chk("hold8_r1", v, 8'h5A);
        rd_reg(3'd0, v); chk("hold8_r0", v, 8'h5A);

        // Reset during EXEC of SLL r5,r4,1
        instr = mk(2'b10, 3'd5, 3'd4, 8'h01);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstx_exec_a", alu_data_1, 8'h1E);
        rst = 1'b1;
        #1;
        chk("rstx_ready", instr_ready, 1);
        chk("rstx_wb_done", wb_done, 0);
        chk("rstx_alu1", alu_data_1, 0);
        chk("rstx_alu2", alu_data_2, 0);
        wbc = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wb_done) wbc++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wb_done) wbc++;
        end
        chk("rstx_no_pulse", wbc, 0);
        rd_reg(3'd5, v); chk("rstx_r5", v, 0);
        rd_reg(3'd4, v); chk("rstx_r4", v, 0);
        issue(mk(2'b01, 3'd5, 3'd0, 8'h3C), lat, rdy1, a2, sh2);
        chk("resume_lat", lat, 2);
        @(posedge clk); #1;
        rd_reg(3'd5, v); chk("resume_r5", v, 8'h3C);

`ifdef SHIFT_EXEC_FLAGS_EN
        chk("flags_rst_z", flag_z, 0);
        chk("flags_rst_c", flag_c, 0);
        issue(mk(2'b01, 3'd1, 3'd0, 8'h80), lat, rdy1, a2, sh2);
        @(posedge clk); #1;
        chk("flags_li_z", flag_z, 0);
        chk("flags_li_c", flag_c, 0);
        issue(mk(2'b10, 3'd2, 3'd1, 8'h01), lat, rdy1, a2, sh2);
        @(posedge clk); #1;
        rd_reg(3'd2, v); chk("flags_sll_r2", v, 8'h00);
        chk("flags_sll_z", flag_z, 1);
        chk("flags_sll_c", flag_c, 1);
        issue(mk(2'b00, 3'd0, 3'd0, 8'h00), lat, rdy1, a2, sh2);
        @(posedge clk); #1;
        chk("flags_nop_z", flag_z, 1);
        chk("flags_nop_c", flag_c, 1);
        issue(mk(2'b01, 3'd3, 3'd0, 8'h00), lat, rdy1, a2, sh2);
        @(posedge clk); #1;
        chk("flags_li0_z", flag_z, 1);
        chk("flags_li0_c", flag_c, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
